shift_rows: RTL and testbench
=============================

SHIFT_ROWS -- requirements
Module: shift_rows

Interface
REQ-001 Parameter INVERSE, default 0; 0 = forward AES ShiftRows, 1 = inverse (InvShiftRows); the two former variants are instances of this one module.
REQ-002 clk  input  1  rising-edge clock, the only clock.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 in_valid  input  1  data_in is valid this cycle.
REQ-005 data_in  input  128  AES state in.
REQ-006 out_valid  output  1  data_out holds a freshly registered result.
REQ-007 data_out  output  128  permuted state, registered.

Function
REQ-008 State layout SHALL be column-major: byte k = data_in[127-8k -: 8]; byte k is row r = k mod 4, column c = k div 4.
REQ-009 Forward: out[r][c] = in[r][(c+r) mod 4]; row r rotates left by r bytes.
REQ-010 Inverse: out[r][c] = in[r][(c-r) mod 4]; row r rotates right by r bytes.
REQ-011 Row 0 SHALL pass unchanged in both directions; bytes never change value, only position.
REQ-012 Latency SHALL be exactly 1 clk: result of data_in sampled at edge N appears on data_out after edge N.
REQ-013 in_valid=1 at an edge: data_out loads the permutation, out_valid=1.
REQ-014 in_valid=0 at an edge: data_out holds its previous value, out_valid=0.
REQ-015 Throughput SHALL be one state per cycle with no back-pressure; back-to-back in_valid accepted every cycle.
REQ-016 Forward and inverse instances in series SHALL return the original state after 2 cycles.

Reset
REQ-017 rst=1 at an edge: data_out=128'h0, out_valid=0, overriding in_valid.
REQ-018 rst asserted mid-stream discards the pending result; first valid output after release appears 1 cycle after the first in_valid sampled with rst=0.

Configuration
REQ-019 Macro SHIFT_ROWS_DYN_INV_EN defined: extra input port inv (1 bit) selects inverse when 1, forward when 0, sampled with data_in on the same edge; INVERSE is ignored.
REQ-020 Macro undefined: no inv port; direction fixed by INVERSE.

Structure
REQ-021 Package shift_rows_pkg SHALL hold: byte_t (8 bits), state_t (16 x byte_t), constants NB=4 and STATE_W=128, and forward/inverse index functions mapping (r,c) to source byte index.
REQ-022 One combinational sub-module shift_rows_perm (state in, dir in, state out) SHALL implement the permutation; shift_rows adds only registers, valid and reset.

Verification
REQ-023 Forward, in 000102030405060708090A0B0C0D0E0F -> 1 cycle later 00050A0F04090E03080D02070C01060B, out_valid=1.
REQ-024 Inverse, in 00050A0F04090E03080D02070C01060B -> 000102030405060708090A0B0C0D0E0F.
REQ-025 Forward, in 0F0F0F0F90CF90CF0F0F0F0F90CF90CF -> 0FCF0FCF900F900F0FCF0FCF900F900F; feeding that to the inverse instance returns the original value exactly.
REQ-026 rst=1 with in_valid=1 -> data_out=0, out_valid=0; then in_valid=0 for 3 cycles -> data_out holds, out_valid=0.
REQ-027 Three back-to-back valid inputs -> three consecutive correct outputs, each 1 cycle after its input, out_valid high 3 cycles.
REQ-028 With SHIFT_ROWS_DYN_INV_EN: alternate inv=0/1 on the same input each cycle -> outputs alternate forward/inverse results.

Source files
------------

// File: rtl/shift_rows_pkg.sv
// shift_rows_pkg: AES state types, sizes and ShiftRows source-index helpers
package shift_rows_pkg;
    localparam int NB = 4;
    localparam int STATE_W = 128;
    typedef logic [7:0] byte_t;
    typedef byte_t [0:4*NB-1] state_t;
    function automatic int fwd_idx(input int r, input int c);
        return NB * ((c + r) % NB) + r;
    endfunction
    function automatic int inv_idx(input int r, input int c);
        return NB * ((c - r + NB) % NB) + r;
    endfunction
endpackage

// File: rtl/shift_rows_perm.sv
// shift_rows_perm: combinational ShiftRows (i_inv=0) / InvShiftRows (i_inv=1) byte permutation
module shift_rows_perm
    import shift_rows_pkg::*;
(
    input  state_t i_state,
    input  logic   i_inv,
    output state_t o_state
);
    for (genvar r = 0; r < NB; r++) begin : g_row
        for (genvar c = 0; c < NB; c++) begin : g_col
            localparam int F = fwd_idx(r, c);
            localparam int I = inv_idx(r, c);
            assign o_state[NB*c+r] = i_inv ? i_state[I] : i_state[F];
        end
    end
endmodule

// File: rtl/shift_rows.sv
// shift_rows: registered AES ShiftRows/InvShiftRows, one state per clock, 1-cycle latency.
// SHIFT_ROWS_DYN_INV_EN adds an inv port choosing the direction per input, overriding INVERSE.
module shift_rows
    import shift_rows_pkg::*;
#(
    parameter bit INVERSE = 1'b0
) (
    input  logic               clk,
    input  logic               rst,
`ifdef SHIFT_ROWS_DYN_INV_EN
    input  logic               inv,
`endif
    input  logic               in_valid,
    input  logic [STATE_W-1:0] data_in,
    output logic               out_valid,
    output logic [STATE_W-1:0] data_out
);
    logic   w_inv;
    state_t w_in;
    state_t w_perm;
    state_t r_data;
    logic   r_valid;
`ifdef SHIFT_ROWS_DYN_INV_EN
    assign w_inv = inv;
`else
    assign w_inv = INVERSE;
`endif
    assign w_in = state_t'(data_in);
    shift_rows_perm u_perm (
        .i_state(w_in),
        .i_inv  (w_inv),
        .o_state(w_perm)
    );
    always_ff @(posedge clk) begin
        if (rst) begin
            r_data  <= '0;
            r_valid <= 1'b0;
        end else begin
            r_valid <= in_valid;
            if (in_valid) r_data <= w_perm;
        end
    end
    assign out_valid = r_valid;
    assign data_out  = r_data;
endmodule

// File: tb/tb_shift_rows.sv
// tb_shift_rows: forward, inverse and forward->inverse chain instances checked against a queue scoreboard
module tb_shift_rows;
`ifdef SHIFT_ROWS_DYN_INV_EN
    localparam bit DYN = 1'b1;
`else
    localparam bit DYN = 1'b0;
`endif
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic vin = 1'b0;
    logic dyn_inv = 1'b0;
    logic [127:0] din = '0;
    logic f_v, i_v, c_v;
    logic [127:0] f_d, i_d, c_d;
    int checks = 0;
    int failures = 0;
    logic [127:0] fq[$], iq[$], cq[$];
    logic [127:0] f_last = '0, i_last = '0, c_last = '0;
    logic prev_pend = 1'b0;

    always #5 clk = ~clk;

    shift_rows #(.INVERSE(1'b0)) u_fwd (
        .clk(clk), .rst(rst),
`ifdef SHIFT_ROWS_DYN_INV_EN
        .inv(dyn_inv),
`endif
        .in_valid(vin), .data_in(din), .out_valid(f_v), .data_out(f_d));

    shift_rows #(.INVERSE(1'b1)) u_inv (
        .clk(clk), .rst(rst),
`ifdef SHIFT_ROWS_DYN_INV_EN
        .inv(1'b1),
`endif
        .in_valid(vin), .data_in(din), .out_valid(i_v), .data_out(i_d));

    shift_rows #(.INVERSE(1'b1)) u_chain (
        .clk(clk), .rst(rst),
`ifdef SHIFT_ROWS_DYN_INV_EN
        .inv(1'b1),
`endif
        .in_valid(f_v), .data_in(f_d), .out_valid(c_v), .data_out(c_d));

    // Reference: rebuild each row as a 4-byte list, then rotate it
    function automatic logic [127:0] model(input logic [127:0] s, input logic inv);
        logic [7:0] row[4];
        logic [127:0] o;
        o = '0;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) row[c] = s[127-8*(4*c+r) -: 8];
            for (int c = 0; c < 4; c++)
                o[127-8*(4*c+r) -: 8] = inv ? row[(c + 4 - r) % 4] : row[(c + r) % 4];
        end
        return o;
    endfunction

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %032h expected %032h", name, act, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [127:0] d, input logic sel, input logic r,
                         input logic [127:0] ef, input logic [127:0] ei, input logic [127:0] ec);
        logic pend, cpend;
        logic [127:0] junk;
        vin = v; din = d; dyn_inv = sel; rst = r;
        pend = v && !r;
        cpend = prev_pend && !r;
        if (pend) begin
            fq.push_back(ef);
            iq.push_back(ei);
            cq.push_back(ec);
        end
        if (prev_pend && r && cq.size() > 0) junk = cq.pop_front();
        @(posedge clk);
        #1;
        if (r) begin
            f_last = '0;
            i_last = '0;
        end else if (pend) begin
            f_last = fq.pop_front();
            i_last = iq.pop_front();
        end
        if (r) c_last = '0;
        else if (cpend) c_last = cq.pop_front();
        chk("fwd_valid", {127'b0, f_v}, {127'b0, pend});
        chk("fwd_data", f_d, f_last);
        chk("inv_valid", {127'b0, i_v}, {127'b0, pend});
        chk("inv_data", i_d, i_last);
        chk("chain_valid", {127'b0, c_v}, {127'b0, cpend});
        chk("chain_data", c_d, c_last);
        prev_pend = pend;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) drive(1'b0, $urandom, 1'b0, 1'b0, '0, '0, '0);
    endtask

    task automatic apply(input logic [127:0] d, input logic sel);
        logic [127:0] ef;
        ef = model(d, DYN & sel);
        drive(1'b1, d, sel, 1'b0, ef, model(d, 1'b1), model(ef, 1'b1));
    endtask

    typedef struct {
        logic [127:0] d;
        logic [127:0] f;
        logic [127:0] i;
    } vec_t;
    vec_t tbl[4];

    initial begin
        tbl[0] = '{128'h000102030405060708090A0B0C0D0E0F,
                   128'h00050A0F04090E03080D02070C01060B,
                   128'h000D0A0704010E0B0805020F0C090603};
        tbl[1] = '{128'h00050A0F04090E03080D02070C01060B,
                   128'h0009020B040D060F08010A030C050E07,
                   128'h000102030405060708090A0B0C0D0E0F};
        tbl[2] = '{128'h0F0F0F0F90CF90CF0F0F0F0F90CF90CF,
                   128'h0FCF0FCF900F900F0FCF0FCF900F900F,
                   128'h0FCF0FCF900F900F0FCF0FCF900F900F};
        tbl[3] = '{128'h0, 128'h0, 128'h0};
        drive(1'b1, 128'hDEADBEEF_01234567_89ABCDEF_CAFEF00D, 1'b0, 1'b1, '0, '0, '0);
        drive(1'b1, 128'h11112222333344445555666677778888, 1'b0, 1'b1, '0, '0, '0);
        idle(3);
        for (int k = 0; k < 4; k++)
            drive(1'b1, tbl[k].d, 1'b0, 1'b0, tbl[k].f, tbl[k].i, tbl[k].d);
        idle(2);
        apply(tbl[0].d, 1'b0);
        drive(1'b1, tbl[1].d, 1'b0, 1'b1, '0, '0, '0);
        drive(1'b1, tbl[2].d, 1'b0, 1'b0, tbl[2].f, tbl[2].i, tbl[2].d);
        idle(2);
        for (int k = 0; k < 16; k++) begin
            if ($urandom_range(3) != 0) apply({$urandom, $urandom, $urandom, $urandom}, 1'b0);
            else idle(1);
        end
        idle(1);
`ifdef SHIFT_ROWS_DYN_INV_EN
        for (int k = 0; k < 6; k++) apply(tbl[0].d, k[0]);
        idle(2);
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
